// File: rtl/usb_cmd_pkg.sv
// Shared definitions for the USB RX command framer: FSM states, sync default,
// and the opcode values agreed with the command executor.
package usb_cmd_pkg;

    typedef enum logic [1:0] {
        ST_HUNT    = 2'd0,
        ST_LEN     = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_CSUM    = 2'd3
    } parser_state_t;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    localparam logic [7:0] OP_NOP       = 8'h00;
    localparam logic [7:0] OP_WRITE_MEM = 8'h01;
    localparam logic [7:0] OP_READ_MEM  = 8'h02;
    localparam logic [7:0] OP_RUN       = 8'h03;
    localparam logic [7:0] OP_PING      = 8'h07;

    // Frame checksum is a plain 16-bit modular sum.
    function automatic logic [15:0] csum_add(input logic [15:0] acc, input logic [15:0] word);
        return acc + word;
    endfunction

endpackage

// File: rtl/usb_cmd_parser_if.sv
// RX FIFO read port plus the payload valid/ready stream of the command parser.
interface usb_cmd_parser_if;
    logic [15:0] fifo_q;
    logic        fifo_empty;
    logic        fifo_rdreq;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;

    modport master (
        output fifo_q, fifo_empty, out_ready,
        input  fifo_rdreq, out_data, out_valid, out_last
    );

    modport slave (
        input  fifo_q, fifo_empty, out_ready,
        output fifo_rdreq, out_data, out_valid, out_last
    );
endinterface

// File: rtl/usb_word_fetch.sv
// Non-show-ahead FIFO reader: one read in flight, presents each fetched word to
// the framer and holds it if the framer cannot take it that cycle.
module usb_word_fetch (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        fifo_empty,
    input  logic [15:0] fifo_q,
    output logic        fifo_rdreq,
    input  logic        stall,
    output logic        word_valid,
    output logic [15:0] word_data,
    input  logic        word_consume,
    output logic [23:0] word_count
);
    logic        rd_pending_reg;
    logic        word_held_reg;
    logic [15:0] word_reg;
    logic [23:0] word_count_reg;

    // Gated by reset_n so no word leaves the FIFO while the parser is held in reset.
    assign fifo_rdreq = reset_n & ~fifo_empty & ~rd_pending_reg & ~word_held_reg & ~stall;
    assign word_valid = rd_pending_reg | word_held_reg;
    assign word_data  = word_held_reg ? word_reg : fifo_q;
    assign word_count = word_count_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_pending_reg <= 1'b0;
            word_held_reg  <= 1'b0;
            word_reg       <= '0;
            word_count_reg <= '0;
        end else begin
            rd_pending_reg <= fifo_rdreq;
            if (rd_pending_reg && !word_consume) begin
                word_held_reg <= 1'b1;
                word_reg      <= fifo_q;
            end else if (word_consume) begin
                word_held_reg <= 1'b0;
            end
            if (fifo_rdreq) begin
                word_count_reg <= word_count_reg + 24'd1;
            end
        end
    end

endmodule

// File: rtl/usb_cmd_parser.sv
// Frames RX FIFO words into sync/opcode, length, payload and checksum, streams the
// payload out and reports frame status and debug counters.
module usb_cmd_parser
    import usb_cmd_pkg::*;
#(
    parameter int unsigned MAX_LEN        = 64,
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEFAULT
) (
    input  logic             clk,
    input  logic             reset_n,
    usb_cmd_parser_if.slave  bus,
    output logic             frame_done,
    output logic             frame_ok,
    output logic [7:0]       frame_opcode,
    output logic [15:0]      frame_len,
    output logic [23:0]      word_count,
    output logic [7:0]       err_count
);
    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

    parser_state_t     state_reg, state_next;
    logic [15:0]       acc_reg, acc_next;
    logic [15:0]       rem_reg, rem_next;
    logic [IDLE_W-1:0] idle_reg, idle_next;
    logic [15:0]       out_data_reg, out_data_next;
    logic              out_valid_reg, out_valid_next;
    logic              out_last_reg, out_last_next;
    logic              done_reg, done_next;
    logic              ok_reg, ok_next;
    logic [7:0]        opcode_reg, opcode_next;
    logic [15:0]       len_reg, len_next;
    logic [7:0]        err_reg, err_next;

    logic        word_valid;
    logic [15:0] word_data;
    logic        word_consume;
    logic        err_inc;
    logic        handshake;
    logic        idle_expired;

    usb_word_fetch u_fetch (
        .clk          (clk),
        .reset_n      (reset_n),
        .fifo_empty   (bus.fifo_empty),
        .fifo_q       (bus.fifo_q),
        .fifo_rdreq   (bus.fifo_rdreq),
        .stall        (out_valid_reg & ~bus.out_ready),
        .word_valid   (word_valid),
        .word_data    (word_data),
        .word_consume (word_consume),
        .word_count   (word_count)
    );

    assign handshake    = out_valid_reg & bus.out_ready;
    assign idle_expired = (32'(idle_reg) == TIMEOUT_CYCLES - 1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= ST_HUNT;
            acc_reg       <= '0;
            rem_reg       <= '0;
            idle_reg      <= '0;
            out_data_reg  <= '0;
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
            done_reg      <= 1'b0;
            ok_reg        <= 1'b0;
            opcode_reg    <= '0;
            len_reg       <= '0;
            err_reg       <= '0;
        end else begin
            state_reg     <= state_next;
            acc_reg       <= acc_next;
            rem_reg       <= rem_next;
            idle_reg      <= idle_next;
            out_data_reg  <= out_data_next;
            out_valid_reg <= out_valid_next;
            out_last_reg  <= out_last_next;
            done_reg      <= done_next;
            ok_reg        <= ok_next;
            opcode_reg    <= opcode_next;
            len_reg       <= len_next;
            err_reg       <= err_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        acc_next       = acc_reg;
        rem_next       = rem_reg;
        idle_next      = idle_reg;
        out_data_next  = out_data_reg;
        out_valid_next = out_valid_reg;
        out_last_next  = out_last_reg;
        done_next      = 1'b0;
        ok_next        = 1'b0;
        opcode_next    = opcode_reg;
        len_next       = len_reg;
        err_inc        = 1'b0;
        word_consume   = 1'b0;

        case (state_reg)
            ST_HUNT: begin
                idle_next = '0;
                if (word_valid) begin
                    word_consume = 1'b1;
                    if (word_data[15:8] == SYNC_BYTE) begin
                        opcode_next = word_data[7:0];
                        acc_next    = word_data;
                        state_next  = ST_LEN;
                    end else begin
                        err_inc = 1'b1;
                    end
                end
            end
            ST_LEN: begin
                if (word_valid) begin
                    word_consume = 1'b1;
                    if (word_data > 16'(MAX_LEN)) begin
                        err_inc    = 1'b1;
                        state_next = ST_HUNT;
                    end else begin
                        len_next   = word_data;
                        acc_next   = csum_add(acc_reg, word_data);
                        rem_next   = word_data;
                        state_next = (word_data == 16'd0) ? ST_CSUM : ST_PAYLOAD;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (handshake) begin
                    out_valid_next = 1'b0;
                    out_last_next  = 1'b0;
                    if (out_last_reg) begin
                        state_next = ST_CSUM;
                    end
                end
                // A new word is only taken once the output slot is free.
                if (word_valid && !out_valid_reg) begin
                    word_consume   = 1'b1;
                    out_data_next  = word_data;
                    out_valid_next = 1'b1;
                    out_last_next  = (rem_reg == 16'd1);
                    acc_next       = csum_add(acc_reg, word_data);
                    rem_next       = rem_reg - 16'd1;
                end
            end
            ST_CSUM: begin
                if (word_valid) begin
                    word_consume = 1'b1;
                    done_next    = 1'b1;
                    ok_next      = (word_data == acc_reg);
                    err_inc      = (word_data != acc_reg);
                    state_next   = ST_HUNT;
                end
            end
            default: state_next = ST_HUNT;
        endcase

        // Inside a frame, any cycle without a fetched word counts as idle, including output stalls.
        if (state_reg != ST_HUNT) begin
            if (word_valid) begin
                idle_next = '0;
            end else if (idle_expired) begin
                idle_next      = '0;
                out_valid_next = 1'b0;
                out_last_next  = 1'b0;
                err_inc        = 1'b1;
                state_next     = ST_HUNT;
            end else begin
                idle_next = idle_reg + IDLE_W'(1);
            end
        end

        if (state_next == ST_HUNT) begin
            acc_next = '0;
        end

        err_next = (err_inc && err_reg != 8'hFF) ? err_reg + 8'd1 : err_reg;
    end

    assign bus.out_data  = out_data_reg;
    assign bus.out_valid = out_valid_reg;
    assign bus.out_last  = out_last_reg;
    assign frame_done    = done_reg;
    assign frame_ok      = ok_reg;
    assign frame_opcode  = opcode_reg;
    assign frame_len     = len_reg;
    assign err_count     = err_reg;

endmodule

// File: tb/tb_usb_cmd_parser.sv
// Bench for usb_cmd_parser: directed frame table, stall/timeout/reset sequences,
// and random frame streams checked against a sequential frame-parsing model.
module tb_usb_cmd_parser;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        frame_done, frame_ok;
    logic [7:0]  frame_opcode, err_count;
    logic [15:0] frame_len;
    logic [23:0] word_count;

    usb_cmd_parser_if bus();

    usb_cmd_parser #(
        .MAX_LEN        (64),
        .TIMEOUT_CYCLES (100),
        .SYNC_BYTE      (8'hA5)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .bus          (bus.slave),
        .frame_done   (frame_done),
        .frame_ok     (frame_ok),
        .frame_opcode (frame_opcode),
        .frame_len    (frame_len),
        .word_count   (word_count),
        .err_count    (err_count)
    );

    always #5 clk = ~clk;

    // FIFO model: non-show-ahead, data appears the cycle after rdreq.
    logic [15:0] mem [0:4095];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    assign bus.fifo_empty = (rd_ptr == wr_ptr);

    always @(posedge clk) begin
        if (bus.fifo_rdreq) begin
            bus.fifo_q <= mem[rd_ptr];
            rd_ptr     <= rd_ptr + 1;
        end
    end

    logic [16:0] out_log [$];
    logic        done_log [$];

    always @(negedge clk) begin
        if (reset_n) begin
            if (bus.out_valid && bus.out_ready) out_log.push_back({bus.out_last, bus.out_data});
            if (frame_done) done_log.push_back(frame_ok);
        end
    end

    int n_pass = 0;
    int n_checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] w);
        mem[wr_ptr] = w;
        wr_ptr++;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        step();
        step();
        out_log.delete();
        done_log.delete();
        reset_n = 1'b1;
        step();
    endtask

    // Reference model: walk the word stream frame by frame.
    logic [16:0] exp_pay [$];
    logic        exp_ok [$];
    int          exp_err;

    task automatic model_parse(input int lo, input int hi);
        int i;
        logic [15:0] h, l, s;
        i = lo;
        exp_pay.delete();
        exp_ok.delete();
        exp_err = 0;
        while (i < hi) begin
            h = mem[i];
            i++;
            if (h[15:8] != 8'hA5) begin
                exp_err++;
                continue;
            end
            l = mem[i];
            i++;
            if (l > 16'd64) begin
                exp_err++;
                continue;
            end
            s = h + l;
            for (int k = 0; k < int'(l); k++) begin
                exp_pay.push_back({(k == int'(l) - 1), mem[i]});
                s = s + mem[i];
                i++;
            end
            exp_ok.push_back(mem[i] == s);
            if (mem[i] != s) exp_err++;
            i++;
        end
    endtask

    task automatic gen_frames(input int nframes);
        logic [15:0] hdr, len, sum, w;
        int kind;
        for (int f = 0; f < nframes; f++) begin
            kind = (f == nframes / 2) ? 9 : int'($urandom_range(0, 9));
            if (kind == 0) begin
                w = 16'($urandom);
                if (w[15:8] == 8'hA5) w[15:8] = 8'h5A;
                push(w);
            end else if (kind == 1) begin
                push({8'hA5, 8'($urandom)});
                push(16'($urandom_range(65, 65535)));
            end else begin
                hdr = {8'hA5, 8'($urandom)};
                len = (kind == 9) ? 16'd64 : 16'($urandom_range(0, 6));
                push(hdr);
                push(len);
                sum = hdr + len;
                for (int k = 0; k < int'(len); k++) begin
                    w = 16'($urandom);
                    push(w);
                    sum = sum + w;
                end
                push((kind == 2) ? (sum ^ 16'h0100) : sum);
            end
        end
    endtask

    typedef struct {
        string             name;
        int                nw;
        logic [0:7][15:0]  w;
        int                npay;
        logic [0:3][16:0]  pay;   // {last, data}
        int                ndone;
        logic              ok;    // ok flag of the final frame
        logic [7:0]        op;
        logic [15:0]       len;
        int                err;
    } vec_t;

    function automatic vec_t mk(input string name, input int nw, input logic [0:7][15:0] w,
                                input int npay, input logic [0:3][16:0] pay, input int ndone,
                                input logic ok, input logic [7:0] op, input logic [15:0] len,
                                input int err);
        vec_t v;
        v.name = name; v.nw = nw; v.w = w; v.npay = npay; v.pay = pay;
        v.ndone = ndone; v.ok = ok; v.op = op; v.len = len; v.err = err;
        return v;
    endfunction

    vec_t vecs [5];

    initial begin
        int t, lo, hi, cyc;

        vecs[0] = mk("good", 5, {16'hA501, 16'h0002, 16'h1234, 16'h5678, 16'h0DAF, 48'h0},
                     2, {17'h01234, 17'h15678, 34'h0}, 1, 1'b1, 8'h01, 16'h0002, 0);
        vecs[1] = mk("badsum", 5, {16'hA501, 16'h0002, 16'h1234, 16'h5678, 16'h0DB0, 48'h0},
                     2, {17'h01234, 17'h15678, 34'h0}, 1, 1'b0, 8'h01, 16'h0002, 1);
        vecs[2] = mk("zerolen", 4, {16'h1234, 16'hA507, 16'h0000, 16'hA507, 64'h0},
                     0, '0, 1, 1'b1, 8'h07, 16'h0000, 1);
        vecs[3] = mk("toolong", 6, {16'hA501, 16'h0041, 16'hA502, 16'h0001, 16'hBEEF, 16'h63F2, 32'h0},
                     1, {17'h1BEEF, 51'h0}, 1, 1'b1, 8'h02, 16'h0001, 1);
        vecs[4] = mk("wrap", 7, {16'hA503, 16'h0001, 16'hFFFF, 16'hA503, 16'hA5FF, 16'h0000, 16'hA5FF, 16'h0},
                     1, {17'h1FFFF, 51'h0}, 2, 1'b1, 8'hFF, 16'h0000, 0);

        bus.out_ready = 1'b0;
        #3 reset_n = 1'b0;
        step();
        step();
        check("reset.outs", {bus.out_data, bus.out_valid, bus.out_last, frame_done, frame_ok,
                             frame_opcode, frame_len, bus.fifo_rdreq}, 64'h0);
        check("reset.counts", {word_count, err_count}, 64'h0);
        reset_n = 1'b1;
        step();

        for (int v = 0; v < 5; v++) begin
            do_reset();
            bus.out_ready = 1'b1;
            for (int k = 0; k < vecs[v].nw; k++) push(vecs[v].w[k]);
            repeat (60) step();
            check({vecs[v].name, ".npay"}, out_log.size(), vecs[v].npay);
            for (int k = 0; k < vecs[v].npay && k < out_log.size(); k++)
                check({vecs[v].name, ".pay"}, out_log[k], vecs[v].pay[k]);
            check({vecs[v].name, ".ndone"}, done_log.size(), vecs[v].ndone);
            if (done_log.size() > 0) check({vecs[v].name, ".ok"}, done_log[$], vecs[v].ok);
            check({vecs[v].name, ".opcode"}, frame_opcode, vecs[v].op);
            check({vecs[v].name, ".len"}, frame_len, vecs[v].len);
            check({vecs[v].name, ".err"}, err_count, vecs[v].err);
            check({vecs[v].name, ".word_count"}, word_count, vecs[v].nw);
            $display("vec %s: %0d payload words, %0d frames, err_count %0d",
                     vecs[v].name, out_log.size(), done_log.size(), err_count);
        end

        // Output stall: data held, no FIFO reads until released.
        do_reset();
        bus.out_ready = 1'b0;
        push(16'hA501); push(16'h0002); push(16'h1234); push(16'h5678); push(16'h0DAF);
        t = 0;
        while (!bus.out_valid && t < 50) begin step(); t++; end
        check("stall.valid_seen", bus.out_valid, 1'b1);
        repeat (5) begin
            step();
            check("stall.hold", {bus.out_valid, bus.out_last, bus.out_data, bus.fifo_rdreq},
                  {1'b1, 1'b0, 16'h1234, 1'b0});
        end
        bus.out_ready = 1'b1;
        repeat (60) step();
        check("stall.npay", out_log.size(), 2);
        if (out_log.size() == 2) check("stall.pay", {out_log[0], out_log[1]}, {17'h01234, 17'h15678});
        check("stall.ndone", done_log.size(), 1);
        if (done_log.size() > 0) check("stall.ok", done_log[0], 1'b1);
        $display("stall: released after 5 cycles, %0d payload words", out_log.size());

        // Timeout mid-payload with the output stalled.
        do_reset();
        bus.out_ready = 1'b0;
        push(16'hA501); push(16'h0003); push(16'h1111);
        t = 0;
        while (!bus.out_valid && t < 50) begin step(); t++; end
        check("timeout.data", {bus.out_valid, bus.out_data}, {1'b1, 16'h1111});
        t = 0;
        while (err_count == 8'd0 && t < 200) begin step(); t++; end
        check("timeout.err", err_count, 8'd1);
        check("timeout.latency", (t >= 95 && t <= 105), 1'b1);
        check("timeout.valid_dropped", bus.out_valid, 1'b0);
        bus.out_ready = 1'b1;
        push(16'hA501); push(16'h0002); push(16'h1234); push(16'h5678); push(16'h0DAF);
        repeat (60) step();
        check("timeout.next_npay", out_log.size(), 2);
        check("timeout.next_ndone", done_log.size(), 1);
        if (done_log.size() > 0) check("timeout.next_ok", done_log[0], 1'b1);
        check("timeout.err_after", err_count, 8'd1);
        $display("timeout: abort after %0d idle cycles", t);

        // Reset mid-payload: outputs clear at once; leftover FIFO words are hunted.
        bus.out_ready = 1'b0;
        push(16'hA501); push(16'h0002); push(16'h1234); push(16'h5678); push(16'h0DAF);
        t = 0;
        while (!bus.out_valid && t < 50) begin step(); t++; end
        check("midreset.valid_seen", bus.out_valid, 1'b1);
        reset_n = 1'b0;
        #1;
        check("midreset.outs", {bus.out_data, bus.out_valid, bus.out_last, frame_done, frame_ok,
                                frame_opcode, frame_len, bus.fifo_rdreq}, 64'h0);
        check("midreset.counts", {word_count, err_count}, 64'h0);
        step();
        out_log.delete();
        done_log.delete();
        reset_n = 1'b1;
        bus.out_ready = 1'b1;
        repeat (40) step();
        check("midreset.leftover_err", err_count, 8'd2);
        check("midreset.word_count", word_count, 24'd2);
        check("midreset.ndone", done_log.size(), 0);
        $display("midreset: leftover words discarded, err_count %0d", err_count);

        // Random frame stream with random output back-pressure.
        do_reset();
        lo = wr_ptr;
        gen_frames(30);
        hi = wr_ptr;
        model_parse(lo, hi);
        cyc = 0;
        while (!(rd_ptr == wr_ptr && out_log.size() == exp_pay.size() && done_log.size() == exp_ok.size())
               && cyc < 20000) begin
            bus.out_ready = ($urandom_range(0, 3) != 0);
            step();
            cyc++;
        end
        check("rand.drain", cyc < 20000, 1'b1);
        bus.out_ready = 1'b1;
        repeat (20) step();
        check("rand.npay", out_log.size(), exp_pay.size());
        for (int k = 0; k < exp_pay.size() && k < out_log.size(); k++)
            check("rand.pay", out_log[k], exp_pay[k]);
        check("rand.ndone", done_log.size(), exp_ok.size());
        for (int k = 0; k < exp_ok.size() && k < done_log.size(); k++)
            check("rand.ok", done_log[k], exp_ok[k]);
        check("rand.err", err_count, exp_err);
        check("rand.word_count", word_count, hi - lo);
        $display("rand: %0d words, %0d payload words, %0d frames, %0d errors in %0d cycles",
                 hi - lo, exp_pay.size(), exp_ok.size(), exp_err, cyc);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
